// File: rtl/key_sw_pkg.sv
// key_sw_pkg: shared constants and helpers for the key/switch conditioner.
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms at 50 MHz
//   KEY_RESET_LEVEL         : push-buttons are active-low, idle/released = 1
//   SW_RESET_LEVEL          : slide switches idle = 0
//   cnt_width()             : width of the per-bit stable-time counter
package key_sw_pkg;

    localparam int   DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam logic KEY_RESET_LEVEL         = 1'b1;
    localparam logic SW_RESET_LEVEL          = 1'b0;

    // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 is enough.
    // It is clamped to 1 bit so tiny test values still give a legal vector.
    function automatic int cnt_width(input int debounce_cycles);
        int w;
        w = $clog2(debounce_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_sw_conditioner_debounce_bit.sv
// debounce_bit: single-bit synchronizer + stable-time debouncer + edge events.
//   clk_clk : system clock
//   reset   : asynchronous active-high reset
//   raw     : asynchronous board pin
//   level   : debounced level (resets to RESET_LEVEL)
//   rise    : 1-cycle pulse on the first cycle level shows 0->1
//   fall    : 1-cycle pulse on the first cycle level shows 1->0
module debounce_bit
    import key_sw_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk_clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q,   deb_d;
    logic          prev_q,  prev_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        prev_d  = deb_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Count only while the synchronized input disagrees with the output;
        // any agreement (bounce back) clears the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            deb_q   <= RESET_LEVEL;
            prev_q  <= RESET_LEVEL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = deb_q;
    assign rise  = ~prev_q & deb_q;
    assign fall  = prev_q & ~deb_q;

endmodule

// File: rtl/key_sw_conditioner.sv
// key_sw_conditioner: cleans DE2-115 push-buttons and slide switches for PIO.
//   clk_clk     : 50 MHz system clock
//   reset       : asynchronous active-high reset
//   key_raw     : raw push-button pins (pressed = 0)
//   sw_raw      : raw slide-switch pins
//   key_out     : debounced key levels
//   sw_out      : debounced switch levels
//   key_press   : 1-cycle pulse when key_out[i] goes 1->0
//   key_release : 1-cycle pulse when key_out[i] goes 0->1
//   sw_toggle   : 1-cycle pulse on any change of sw_out[i]
module key_sw_conditioner
    import key_sw_pkg::*;
#(
    parameter int N_KEY           = 2,
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk_clk,
    input  logic             reset,
    input  logic [N_KEY-1:0] key_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_KEY-1:0] key_out,
    output logic [N_SW-1:0]  sw_out,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic [N_SW-1:0]  sw_toggle
);

    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;

    // Keys are active-low: a falling level is a press.
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (KEY_RESET_LEVEL)
        ) u_deb (
            .clk_clk(clk_clk),
            .reset  (reset),
            .raw    (key_raw[i]),
            .level  (key_out[i]),
            .rise   (key_release[i]),
            .fall   (key_press[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (SW_RESET_LEVEL)
        ) u_deb (
            .clk_clk(clk_clk),
            .reset  (reset),
            .raw    (sw_raw[i]),
            .level  (sw_out[i]),
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i])
        );
    end

    assign sw_toggle = sw_rise | sw_fall;

endmodule

// File: tb/tb_key_sw_conditioner.sv
module tb_key_sw_conditioner;

    localparam int D = 4;

    logic       clk_clk = 1'b0;
    logic       reset   = 1'b0;
    logic [1:0] key_raw = 2'b11;
    logic [3:0] sw_raw  = 4'h0;
    logic [1:0] key_out, key_press, key_release;
    logic [3:0] sw_out, sw_toggle;

    int errors = 0;
    int checks = 0;

    // Reference model: bits [1:0] keys, [5:2] switches.
    // h holds the raw vector seen at each clock edge; the synchronized value
    // used at edge n is the raw value seen at edge n-2. An output bit flips
    // when the last D synchronized samples all disagree with it.
    logic [5:0] h[$];
    logic [5:0] mdeb, mprev;

    key_sw_conditioner #(.N_KEY(2), .N_SW(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk_clk    (clk_clk),
        .reset      (reset),
        .key_raw    (key_raw),
        .sw_raw     (sw_raw),
        .key_out    (key_out),
        .sw_out     (sw_out),
        .key_press  (key_press),
        .key_release(key_release),
        .sw_toggle  (sw_toggle)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mdeb  = 6'b000011;
        mprev = mdeb;
        h.delete();
        repeat (D + 2) h.push_back(mdeb);
    endtask

    task automatic m_edge();
        logic all_diff;
        h.push_back({sw_raw, key_raw});
        while (h.size() > D + 3) void'(h.pop_front());
        mprev = mdeb;
        for (int b = 0; b < 6; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++)
                if (h[h.size() - 3 - j][b] == mdeb[b]) all_diff = 1'b0;
            if (all_diff) mdeb[b] = ~mdeb[b];
        end
    endtask

    task automatic cmp_all();
        chk("key_out",     {30'd0, key_out},     {30'd0, mdeb[1:0]});
        chk("sw_out",      {28'd0, sw_out},      {28'd0, mdeb[5:2]});
        chk("key_press",   {30'd0, key_press},   {30'd0, mprev[1:0] & ~mdeb[1:0]});
        chk("key_release", {30'd0, key_release}, {30'd0, ~mprev[1:0] & mdeb[1:0]});
        chk("sw_toggle",   {28'd0, sw_toggle},   {28'd0, mprev[5:2] ^ mdeb[5:2]});
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then sample the DUT 1 time unit later.
    task automatic step();
        @(posedge clk_clk);
        if (!reset) m_edge();
        #1;
        cmp_all();
    endtask

    initial begin
        int presses;
        int hold;
        logic [5:0] v;

        // Reset asserted between edges: outputs must clear before any edge.
        key_raw = 2'b00;
        sw_raw  = 4'hF;
        #2 reset = 1'b1;
        m_reset();
        #1;
        chk("rst0_key_out", {30'd0, key_out}, 32'h3);
        chk("rst0_sw_out",  {28'd0, sw_out},  32'h0);
        chk("rst0_pulses",  {24'd0, key_press, key_release, sw_toggle}, 32'h0);
        step();
        step();
        key_raw = 2'b11;
        sw_raw  = 4'h0;
        reset   = 1'b0;
        repeat (D + 3) step();

        // Clean press on key 0: out falls after E5, one press pulse.
        key_raw = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("press_key_out",   {30'd0, key_out},   (k >= 6) ? 32'h2 : 32'h3);
            chk("press_key_press", {30'd0, key_press}, (k == 6) ? 32'h1 : 32'h0);
            chk("press_sw_out",    {28'd0, sw_out},    32'h0);
        end
        key_raw = 2'b11;
        repeat (D + 3) step();

        // Bounce on sw[2]: 3 high, 1 low, 3 high, then low; never reaches out.
        for (int k = 0; k < 12; k++) begin
            sw_raw = ((k < 3) || (k >= 4 && k < 7)) ? 4'h4 : 4'h0;
            step();
            chk("bounce_sw_out",    {28'd0, sw_out},    32'h0);
            chk("bounce_sw_toggle", {28'd0, sw_toggle}, 32'h0);
        end

        // key[1] toggles every cycle for 10 cycles, then settles low.
        presses = 0;
        for (int i = 0; i < 10; i++) begin
            key_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            step();
            presses += int'(key_press[1]);
        end
        key_raw[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            presses += int'(key_press[1]);
            chk("settle_key1", {31'd0, key_out[1]}, (k >= 6) ? 32'h0 : 32'h1);
        end
        chk("settle_presses", presses, 32'd1);
        key_raw = 2'b11;
        repeat (D + 3) step();

        // Simultaneous changes on switches and keys.
        sw_raw  = 4'hA;
        key_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("simul_sw_out",    {28'd0, sw_out},    (k >= 6) ? 32'hA : 32'h0);
            chk("simul_key_out",   {30'd0, key_out},   (k >= 6) ? 32'h0 : 32'h3);
            chk("simul_sw_toggle", {28'd0, sw_toggle}, (k == 6) ? 32'hA : 32'h0);
            chk("simul_key_press", {30'd0, key_press}, (k == 6) ? 32'h3 : 32'h0);
        end

        // Asynchronous reset mid-cycle from a non-reset output state.
        sw_raw = 4'hF;
        #3 reset = 1'b1;
        m_reset();
        #1;
        chk("rst1_key_out", {30'd0, key_out}, 32'h3);
        chk("rst1_sw_out",  {28'd0, sw_out},  32'h0);
        chk("rst1_pulses",  {24'd0, key_press, key_release, sw_toggle}, 32'h0);
        step();
        key_raw = 2'b11;
        sw_raw  = 4'h0;
        reset   = 1'b0;
        repeat (D + 3) step();

        // Reset mid-count: sw[0] high 3 cycles, 1-cycle reset, keep high.
        sw_raw = 4'h1;
        repeat (3) step();
        reset = 1'b1;
        m_reset();
        step();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("rstcnt_sw0",    {31'd0, sw_out[0]},    (k >= 6) ? 32'h1 : 32'h0);
            chk("rstcnt_toggle", {31'd0, sw_toggle[0]}, (k == 6) ? 32'h1 : 32'h0);
        end

        // Random levels held for random lengths, checked against the model.
        for (int n = 0; n < 120; n++) begin
            v       = 6'($urandom);
            key_raw = v[1:0];
            sw_raw  = v[5:2];
            hold    = int'($urandom_range(1, 7));
            repeat (hold) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
